// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and its baud-rate
// timer (and by a matching receiver later on).
//   uart_state_e      - frame sequencing states
//   IDLE_LEVEL        - line level while no frame is being sent
//   DATA_BITS         - payload bits per frame
//   calc_clks_per_bit - clock cycles per serial bit from CLK_FREQ/BAUD
//   calc_cnt_width    - width of a counter covering 0..clks-1 (min 1 bit)
//   even_parity       - XOR of a byte (used only when UART_TX_PARITY_EN is set)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_cnt_width(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period timer.
// The counter runs 0..CLKS_PER_BIT-1 and wraps; tick is high during the
// cycle in which the counter holds its last value, so the consumer advances
// exactly on the wrap edge. While clear is high the counter is held at 0.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   clear - hold the counter at 0 (no ticks)
//   tick  - one-cycle pulse, registered
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            W    = calc_cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0]  PRE  = W'(CLKS_PER_BIT - 2);

  logic [W-1:0] cnt_r;
  logic         tick_r;

  // Bit-period counter; tick is registered one cycle ahead (counter at
  // PRE) so it lines up with the counter holding LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_r + W'(1);
      tick_r <= (cnt_r == PRE);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-byte-per-handshake UART transmitter, LSB first.
// Frame is 8N1 by default; with macro UART_TX_PARITY_EN defined an even
// parity bit is inserted after the data bits (8E1).
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset (line forced idle at once)
//   data     - byte to send, latched only on an accepted handshake
//   new_data - send request
//   block    - flow-control hold-off, gates acceptance only
//   busy     - high from the cycle after acceptance until the frame ends
//   tx       - serial line, idle high
// A byte is accepted when idle, new_data is high and block is low. A held
// new_data is accepted again in the first idle cycle, so back-to-back
// frames show a stop bit one cycle longer than nominal.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       busy,
  output logic       tx
);

  localparam int         CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_byte: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  uart_state_e state_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_idx_r;
  logic        tx_r;
  logic        busy_r;
  logic        tick_s;
  logic        clear_s;
`ifdef UART_TX_PARITY_EN
  logic        parity_r;
`endif

  // The timer only runs while a frame is in flight, so every frame starts
  // from a full bit period.
  assign clear_s = (state_r == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear_s),
    .tick (tick_s)
  );

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      tx_r      <= IDLE_LEVEL;
      busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          bit_idx_r <= 3'd0;
          if (new_data && !block) begin
            shift_r <= data;
`ifdef UART_TX_PARITY_EN
            parity_r <= even_parity(data);
`endif
            state_r <= START;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r   <= IDLE_LEVEL;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_idx_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_r <= PARITY;
              tx_r    <= parity_r;
`else
              state_r <= STOP;
              tx_r    <= IDLE_LEVEL;
`endif
            end else begin
              // Next bit comes from position 1 before the shift lands.
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            state_r <= STOP;
            tx_r    <= IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (tick_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            tx_r    <= IDLE_LEVEL;
          end
        end
        default: begin
          // Unreachable encodings recover to a quiet line.
          state_r <= IDLE;
          busy_r  <= 1'b0;
          tx_r    <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;

endmodule
